// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: issue opcodes, FSM states,
// and the default divide iteration count.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ONE,
      S_DIV,
      S_FIX
   } state_t;

   localparam int DIV_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/muldiv_div_iter.sv
// Unsigned restoring divider datapath: load latches the operands, each step
// retires one quotient bit. Sign handling and sequencing live in the parent.
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dsr_q;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;

   // The partial remainder stays below the divisor, so the extra top bit of
   // diff is a clean borrow flag.
   always_comb begin
      shifted = {rem_q, quo_q[DATA_W-1]};
      diff    = shifted - {1'b0, dsr_q};
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
      end else if (step) begin
         if (!diff[DATA_W]) begin
            rem_q <= diff[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
         end else begin
            rem_q <= shifted[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit holding HI/LO: single-cycle products,
// iterative divides, MTHI/MTLO writes that also abort an in-flight op.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startE,
   input  logic [1:0]        opE,
   input  logic [DATA_W-1:0] srcaE,
   input  logic [DATA_W-1:0] srcbE,
   input  logic              mthiE,
   input  logic              mtloE,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              hiwrite,
   output logic              lowrite
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);

   state_t              state;
   op_t                 op;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   hi_q, lo_q, stage_hi, stage_lo;
   logic                neg_q, neg_r;
   logic                mt_any, is_signed, is_div, div_zero;
   logic                ext_a, ext_b, div_load, div_step, result_cycle;
   logic [2*DATA_W-1:0] product;
   logic [DATA_W-1:0]   mag_a, mag_b, quotient, remainder, q_fix, r_fix;

   assign op        = op_t'(opE);
   assign mt_any    = mthiE | mtloE;
   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign div_zero  = (srcbE == '0);

   // Sign-extending to double width lets one unsigned multiplier serve both
   // flavours; the low 2*DATA_W bits are the correct product either way.
   assign ext_a   = is_signed & srcaE[DATA_W-1];
   assign ext_b   = is_signed & srcbE[DATA_W-1];
   assign product = {{DATA_W{ext_a}}, srcaE} * {{DATA_W{ext_b}}, srcbE};

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      mag_a = srcaE;
      mag_b = srcbE;
      if (ext_a) mag_a = -srcaE;
      if (ext_b) mag_b = -srcbE;
   end

   always_comb begin
      q_fix = quotient;
      r_fix = remainder;
      if (neg_q) q_fix = -quotient;
      if (neg_r) r_fix = -remainder;
   end

   assign div_load = (state == S_IDLE) && startE && !mt_any && is_div && !div_zero;
   assign div_step = (state == S_DIV) && !mt_any;

   div_iter #(.DATA_W(DATA_W)) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         stage_hi <= '0;
         stage_lo <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (mt_any) begin
         // An MT write always wins: it drops a same-cycle start and aborts
         // any operation in flight without touching the other register.
         if (mthiE) hi_q <= srcaE;
         if (mtloE) lo_q <= srcaE;
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (startE) begin
                  if (!is_div) begin
                     stage_hi <= product[2*DATA_W-1:DATA_W];
                     stage_lo <= product[DATA_W-1:0];
                     state    <= S_ONE;
                  end else if (div_zero) begin
                     stage_hi <= srcaE;
                     stage_lo <= '1;
                     state    <= S_ONE;
                  end else begin
                     neg_q <= ext_a ^ ext_b;
                     neg_r <= ext_a;
                     cnt   <= '0;
                     state <= S_DIV;
                  end
               end
            end
            S_ONE: begin
               hi_q  <= stage_hi;
               lo_q  <= stage_lo;
               state <= S_IDLE;
            end
            S_DIV: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DIV_CYCLES - 1)) state <= S_FIX;
            end
            S_FIX: begin
               hi_q  <= r_fix;
               lo_q  <= q_fix;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign result_cycle = ((state == S_ONE) || (state == S_FIX)) && !mt_any;

   assign hi      = hi_q;
   assign lo      = lo_q;
   assign busy    = (state != S_IDLE);
   assign done    = result_cycle;
   assign hiwrite = mthiE | result_cycle;
   assign lowrite = mtloE | result_cycle;

endmodule
